// File: rtl/bus_arb_pkg.sv
// Shared state encoding and wait-state selection for the 8088 bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CPU_ACT      = 2'd1,
    DMA_ACT      = 2'd2,
    DMA_CPU_PEND = 2'd3
  } arb_state_t;

  // INTA cycles take IO timing even when IOM is low.
  function automatic int unsigned wait_load(input logic iom, input logic inta,
                                            input int unsigned mem_wait,
                                            input int unsigned io_wait);
    return (iom || inta) ? io_wait : mem_wait;
  endfunction

endpackage

// File: rtl/bus_wait_counter.sv
// Wait-state down-counter: loads on strobe, decrements per bus clock edge, reports zero of next value.
// Latency: zero_nxt is combinational from the registered count; load wins over a coinciding decrement.
module bus_wait_counter #(
  parameter int WAIT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              zero_nxt
);

  logic [WAIT_W-1:0] cnt;
  logic [WAIT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (load)
      cnt_d = load_val;
    else if (dec && cnt != '0)
      cnt_d = cnt - WAIT_W'(1);
  end

  assign zero_nxt = (cnt_d == '0);

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else
      cnt <= cnt_d;
  end

endmodule

// File: rtl/bus_arbiter.sv
// 8088 bus sequencer/arbiter: shares the bus between CPU and one DMA requester; outputs registered, 1-cycle response.
// Backpressure: the CPU is held via READY_IN during wait states and while DMA owns the bus.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MEM_WAIT     = 0,
  parameter int unsigned IO_WAIT      = 1,
  parameter int unsigned DMA_MAX_WAIT = 4,
  parameter int          WAIT_W       = 4
) (
  input  logic       CORE_CLK_INT,
  input  logic       RESET_INT,
  input  logic       BUS_CLK_EDGE,
  input  logic       ALE,
  input  logic       RD_n,
  input  logic       WR_n,
  input  logic       INTA_n,
  input  logic       IOM,
  input  logic       DMA_REQ,
  input  logic       DMA_DONE,
  output logic       READY_IN,
  output logic       DMA_GNT,
  output logic       BUS_SEL_DMA,
  output logic [1:0] ARB_STATE
);

  localparam int unsigned MAX_LOAD = (32'd1 << WAIT_W) - 32'd1;

  if (MEM_WAIT > MAX_LOAD || IO_WAIT > MAX_LOAD || DMA_MAX_WAIT > MAX_LOAD) begin : g_cfg_err
    $error("bus_arbiter: wait parameter does not fit in WAIT_W bits");
  end

  arb_state_t        state, state_nxt;
  logic [WAIT_W-1:0] streak, streak_nxt, load_val;
  logic              strobe_seen, strobe_seen_nxt, io_q, io_q_nxt;
  logic              load, turn, load_iom, load_inta, wait_zero_nxt;
  logic              strobe_low, done, dma_prio, ready_nxt, own_nxt;
  int unsigned       load_sel;

  assign strobe_low = !RD_n || !WR_n || !INTA_n;
  // A DMA requester that drops its request without DONE has finished.
  assign done       = DMA_DONE || !DMA_REQ;
  assign dma_prio   = DMA_REQ && (32'(streak) >= DMA_MAX_WAIT);

  always_comb begin
    state_nxt       = state;
    streak_nxt      = streak;
    strobe_seen_nxt = strobe_seen;
    io_q_nxt        = io_q;
    load            = 1'b0;
    turn            = 1'b0;
    load_iom        = IOM;
    load_inta       = !INTA_n;
    case (state)
      IDLE: begin
        strobe_seen_nxt = 1'b0;
        if (ALE && !dma_prio) begin
          state_nxt = CPU_ACT;
          load      = 1'b1;
        end else if (DMA_REQ) begin
          state_nxt = ALE ? DMA_CPU_PEND : DMA_ACT;
          io_q_nxt  = IOM || !INTA_n;
        end
      end
      CPU_ACT: begin
        if (strobe_low) begin
          strobe_seen_nxt = 1'b1;
        end else if (strobe_seen) begin
          state_nxt       = IDLE;
          strobe_seen_nxt = 1'b0;
          if (!DMA_REQ)
            streak_nxt = '0;
          else if (streak != '1)
            streak_nxt = streak + WAIT_W'(1);
        end
      end
      DMA_ACT: begin
        streak_nxt = '0;
        if (ALE)
          io_q_nxt = IOM || !INTA_n;
        if (done && ALE) begin
          state_nxt = CPU_ACT;
          load      = 1'b1;
          turn      = 1'b1;
        end else if (done) begin
          state_nxt = IDLE;
        end else if (ALE) begin
          state_nxt = DMA_CPU_PEND;
        end
      end
      default: begin
        streak_nxt = '0;
        load_iom   = io_q;
        load_inta  = 1'b0;
        if (done) begin
          state_nxt = CPU_ACT;
          load      = 1'b1;
          turn      = 1'b1;
        end
      end
    endcase
  end

  // The extra wait after a DMA hand-back covers bus turnaround.
  assign load_sel = wait_load(load_iom, load_inta, MEM_WAIT, IO_WAIT) + (turn ? 32'd1 : 32'd0);
  assign load_val = (load_sel > MAX_LOAD) ? '1 : load_sel[WAIT_W-1:0];

  bus_wait_counter #(
    .WAIT_W(WAIT_W)
  ) u_wait (
    .clk     (CORE_CLK_INT),
    .rst     (RESET_INT),
    .load    (load),
    .load_val(load_val),
    .dec     (BUS_CLK_EDGE),
    .zero_nxt(wait_zero_nxt)
  );

  assign ready_nxt = (state_nxt == CPU_ACT) ? wait_zero_nxt : (state_nxt != DMA_CPU_PEND);
  assign own_nxt   = (state_nxt == DMA_ACT) || (state_nxt == DMA_CPU_PEND);

  always_ff @(posedge CORE_CLK_INT) begin
    if (RESET_INT) begin
      state       <= IDLE;
      streak      <= '0;
      strobe_seen <= 1'b0;
      io_q        <= 1'b0;
      READY_IN    <= 1'b1;
      DMA_GNT     <= 1'b0;
      BUS_SEL_DMA <= 1'b0;
    end else begin
      state       <= state_nxt;
      streak      <= streak_nxt;
      strobe_seen <= strobe_seen_nxt;
      io_q        <= io_q_nxt;
      READY_IN    <= ready_nxt;
      DMA_GNT     <= own_nxt;
      BUS_SEL_DMA <= own_nxt;
    end
  end

  assign ARB_STATE = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: stimulus queues expected outputs per cycle, a negedge monitor compares.
module tb_bus_arbiter;
  import bus_arb_pkg::*;

  logic       clk = 1'b0;
  logic       rst, bus_edge, ale, rd_n, wr_n, inta_n, iom, dma_req, dma_done;
  logic       ready_in, dma_gnt, bus_sel_dma;
  logic [1:0] arb_state;

  bus_arbiter #(
    .MEM_WAIT(0), .IO_WAIT(2), .DMA_MAX_WAIT(4), .WAIT_W(4)
  ) dut (
    .CORE_CLK_INT(clk), .RESET_INT(rst), .BUS_CLK_EDGE(bus_edge), .ALE(ale),
    .RD_n(rd_n), .WR_n(wr_n), .INTA_n(inta_n), .IOM(iom), .DMA_REQ(dma_req),
    .DMA_DONE(dma_done), .READY_IN(ready_in), .DMA_GNT(dma_gnt),
    .BUS_SEL_DMA(bus_sel_dma), .ARB_STATE(arb_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       ready;
    logic       gnt;
    logic       sel;
    logic [1:0] st;
  } exp_t;

  exp_t  eq[$];
  string nq[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic  stim_done = 1'b0;
  exp_t  me;
  string mn;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs d core edges from now (d=0: the current cycle).
  task automatic chk(input int d, input logic r, input logic g, input logic s,
                     input logic [1:0] st, input string nm);
    exp_t e;
    e.cyc = cyc + d; e.ready = r; e.gnt = g; e.sel = s; e.st = st;
    eq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    while (eq.size() > 0 && eq[0].cyc <= cyc) begin
      me = eq.pop_front();
      mn = nq.pop_front();
      n_cmp++;
      if (me.cyc != cyc || ready_in !== me.ready || dma_gnt !== me.gnt ||
          bus_sel_dma !== me.sel || arb_state !== me.st) begin
        n_bad++;
        $display("FAIL %s: got rdy=%b gnt=%b sel=%b st=%0d, want rdy=%b gnt=%b sel=%b st=%0d (cyc %0d/%0d)",
                 mn, ready_in, dma_gnt, bus_sel_dma, arb_state,
                 me.ready, me.gnt, me.sel, me.st, cyc, me.cyc);
      end
    end
    if (stim_done) begin
      while (eq.size() > 0) begin
        me = eq.pop_front();
        mn = nq.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s: never sampled, want st=%0d at cyc %0d", mn, me.st, me.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1; bus_edge = 1'b0; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
    inta_n = 1'b1; iom = 1'b0; dma_req = 1'b0; dma_done = 1'b0;
    step(3);
    rst = 1'b0;
    chk(0, 1, 0, 0, IDLE, "reset");

    // Memory read, zero wait states
    ale = 1'b1; iom = 1'b0;
    chk(1, 1, 0, 0, CPU_ACT, "mem_ale");
    step(1);
    ale = 1'b0; rd_n = 1'b0; bus_edge = 1'b1;
    chk(1, 1, 0, 0, CPU_ACT, "mem_rd");
    step(2);
    rd_n = 1'b1; bus_edge = 1'b0;
    chk(1, 1, 0, 0, IDLE, "mem_end");
    step(1);

    // IO write, two wait states; the edge coinciding with ALE must not count
    ale = 1'b1; iom = 1'b1; bus_edge = 1'b1;
    chk(1, 0, 0, 0, CPU_ACT, "io_ale");
    step(1);
    ale = 1'b0; wr_n = 1'b0; bus_edge = 1'b0;
    chk(1, 0, 0, 0, CPU_ACT, "io_w0");
    step(1);
    bus_edge = 1'b1;
    chk(1, 0, 0, 0, CPU_ACT, "io_p1");
    step(1);
    bus_edge = 1'b0;
    chk(1, 0, 0, 0, CPU_ACT, "io_hold");
    step(1);
    bus_edge = 1'b1;
    chk(1, 1, 0, 0, CPU_ACT, "io_p2");
    step(1);
    bus_edge = 1'b0; wr_n = 1'b1; iom = 1'b0;
    chk(1, 1, 0, 0, IDLE, "io_end");
    step(1);

    // DONE outside a DMA state is ignored
    dma_done = 1'b1;
    chk(1, 1, 0, 0, IDLE, "done_ignored");
    step(1);
    dma_done = 1'b0;

    // DMA grant, done after 10 cycles, regrant no earlier than n+2
    dma_req = 1'b1;
    chk(1, 1, 1, 1, DMA_ACT, "dma_gnt");
    step(10);
    dma_done = 1'b1;
    chk(1, 1, 0, 0, IDLE, "dma_done");
    step(1);
    dma_done = 1'b0;
    chk(1, 1, 1, 1, DMA_ACT, "dma_regnt");
    step(1);
    dma_req = 1'b0;
    chk(1, 1, 0, 0, IDLE, "dma_reqfall");
    step(1);

    // CPU cycle started during DMA: stalled, then one turnaround wait
    dma_req = 1'b1;
    step(1);
    ale = 1'b1; iom = 1'b0;
    chk(1, 0, 1, 1, DMA_CPU_PEND, "pend_enter");
    step(1);
    ale = 1'b0;
    step(2);
    chk(1, 0, 1, 1, DMA_CPU_PEND, "pend_hold");
    step(1);
    dma_done = 1'b1;
    chk(1, 0, 0, 0, CPU_ACT, "pend_done");
    step(1);
    dma_done = 1'b0; dma_req = 1'b0; rd_n = 1'b0;
    chk(1, 0, 0, 0, CPU_ACT, "pend_wait");
    step(1);
    bus_edge = 1'b1;
    chk(1, 1, 0, 0, CPU_ACT, "pend_w1");
    step(1);
    bus_edge = 1'b0; rd_n = 1'b1;
    chk(1, 1, 0, 0, IDLE, "pend_end");
    step(1);

    // Four back-to-back CPU cycles with DMA pending, then DMA wins over ALE
    dma_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ale = 1'b1; iom = 1'b0;
      chk(1, 1, 0, 0, CPU_ACT, "streak_ale");
      step(1);
      ale = 1'b0; rd_n = 1'b0;
      step(1);
      rd_n = 1'b1;
      chk(1, 1, 0, 0, IDLE, "streak_end");
      step(1);
    end
    ale = 1'b1;
    chk(1, 0, 1, 1, DMA_CPU_PEND, "prio_grant");
    step(1);
    ale = 1'b0;

    // Reset while pending aborts everything
    rst = 1'b1;
    chk(1, 1, 0, 0, IDLE, "rst_pend");
    step(1);
    rst = 1'b0; dma_req = 1'b0;
    chk(1, 1, 0, 0, IDLE, "rst_after");
    step(2);

    stim_done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
